led_pattern_display: RTL

Parametrised LED output stage for board status indication. It latches a pattern, mode and brightness level on a load strobe, then drives the LEDs in one of four modes: static, blink, PWM dim, or rotating marquee. It sits between control logic (key scan, sensor status, frame counters) and the LED pins. It replaces the simple enable-latch LED register for any design that needs animated or dimmed indication.

---
 rtl/led_pattern_display_pkg.sv | 12 +
 rtl/led_pattern_display_tick_gen.sv | 39 +++
 rtl/led_pattern_display.sv | 95 +++++++++
 3 files changed

// File: rtl/led_pattern_display_pkg.sv
// Shared definitions for the LED pattern display and related status blocks.
`timescale 1ns/1ps
package led_pattern_display_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_STATIC  = 2'd0;
  localparam mode_t MODE_BLINK   = 2'd1;
  localparam mode_t MODE_PWM     = 2'd2;
  localparam mode_t MODE_MARQUEE = 2'd3;

endpackage

// File: rtl/led_pattern_display_tick_gen.sv
// Base-tick prescaler and step counter. A synchronous clear restarts both counters.
`timescale 1ns/1ps
module led_tick_gen #(
  parameter int TICK_DIV   = 50000,
  parameter int STEP_TICKS = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic step
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PW-1:0] PRE_TOP  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_TOP = SW'(STEP_TICKS - 1);

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_step_cnt;

  assign tick = (r_presc == PRE_TOP);
  assign step = tick && (r_step_cnt == STEP_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_step_cnt <= '0;
    end else if (clr) begin
      r_presc    <= '0;
      r_step_cnt <= '0;
    end else begin
      r_presc <= tick ? '0 : r_presc + 1'b1;
      if (tick)
        r_step_cnt <= (r_step_cnt == STEP_TOP) ? '0 : r_step_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_display.sv
// LED output stage: latches pattern/mode/level on a load strobe and drives
// static, blinking, PWM-dimmed or rotating-marquee indication.
`timescale 1ns/1ps
module led_pattern_display
  import led_pattern_display_pkg::*;
#(
  parameter int LED_WIDTH  = 8,
  parameter int TICK_DIV   = 50000,
  parameter int STEP_TICKS = 250,
  parameter int PWM_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 led_en,
  input  logic [LED_WIDTH-1:0] led_value,
  input  logic [1:0]           led_mode,
  input  logic [PWM_BITS-1:0]  led_level,
  output logic [LED_WIDTH-1:0] led_data,
  output logic                 step_pulse
);

  localparam logic [PWM_BITS-1:0] PWM_TOP = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [LED_WIDTH-1:0] r_pattern;
  mode_t                r_mode;
  logic [PWM_BITS-1:0]  r_level;
  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic                 r_phase;
  logic                 r_step_p1;
  logic                 w_tick;
  logic                 w_step;
  logic                 w_step_evt;
  logic                 w_pwm_on;
  logic [LED_WIDTH-1:0] w_led_next;

  function automatic logic [LED_WIDTH-1:0] rotl1(input logic [LED_WIDTH-1:0] p);
    return (p << 1) | (p >> (LED_WIDTH - 1));
  endfunction

  led_tick_gen #(
    .TICK_DIV   (TICK_DIV),
    .STEP_TICKS (STEP_TICKS)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (led_en),
    .tick  (w_tick),
    .step  (w_step)
  );

  assign w_step_evt = w_tick && w_step;
  assign w_pwm_on   = (r_pwm_cnt < r_level);

  always_comb begin
    w_led_next = r_pattern;
    case (r_mode)
      MODE_BLINK: if (!r_phase)  w_led_next = '0;
      MODE_PWM:   if (!w_pwm_on) w_led_next = '0;
      default:    w_led_next = r_pattern;
    endcase
  end

  // Stage p0: captured state and counters; stage p1: registered LED drive and step pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern  <= '0;
      r_mode     <= MODE_STATIC;
      r_level    <= '0;
      r_pwm_cnt  <= '0;
      r_phase    <= 1'b1;
      r_step_p1  <= 1'b0;
      led_data   <= '0;
      step_pulse <= 1'b0;
    end else begin
      led_data   <= w_led_next;
      step_pulse <= r_step_p1;
      if (led_en) begin
        r_pattern <= led_value;
        r_mode    <= led_mode;
        r_level   <= led_level;
        r_pwm_cnt <= '0;
        r_phase   <= 1'b1;
        r_step_p1 <= 1'b0;
      end else begin
        r_pwm_cnt <= (r_pwm_cnt == PWM_TOP) ? '0 : r_pwm_cnt + 1'b1;
        r_step_p1 <= w_step_evt;
        if (w_step_evt) begin
          if (r_mode == MODE_BLINK)   r_phase   <= ~r_phase;
          if (r_mode == MODE_MARQUEE) r_pattern <= rotl1(r_pattern);
        end
      end
    end
  end

endmodule
